seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 SHALL have port clock  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to divide; accepted only when ready=1.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, sampled at acceptance.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, sampled at acceptance.
REQ-007 SHALL have port ready  output  1  high only in IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; results valid.
REQ-009 SHALL have port quotient  output  WIDTH  result quotient.
REQ-010 SHALL have port remainder  output  WIDTH  result remainder.
REQ-011 SHALL have port div_by_zero  output  1  the divisor of the last result was zero.

Function
REQ-012 SHALL implement states IDLE, RUN, FIX and DONE.
REQ-013 SHALL transition IDLE->RUN, RUN->FIX, FIX->DONE and DONE->IDLE; no other transitions occur except on reset.
REQ-014 SHALL accept an operation on a rising edge where start=1 and ready=1, latching both operands and moving to RUN.
REQ-015 SHALL ignore start while ready=0; operands presented then are neither latched nor queued.
REQ-016 SHALL perform one restoring shift/subtract iteration per cycle in RUN, producing one quotient bit MSB-first, for exactly WIDTH cycles.
REQ-017 SHALL use FIX for sign correction and the zero-divisor override, and SHALL occupy FIX for one cycle in every build.
REQ-018 SHALL assert done in DONE, giving a fixed latency: done is high in the cycle starting WIDTH+2 edges after the accepting edge, i.e. 34 edges for WIDTH=32.
REQ-019 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next accepting edge.
REQ-020 SHALL allow back-to-back operation: start may be accepted in the first IDLE cycle after DONE.
REQ-021 SHALL, for divisor=0, return quotient all-ones, remainder=dividend and div_by_zero=1, with the normal latency.
REQ-022 SHALL keep the remainder magnitude strictly less than the divisor magnitude when divisor!=0.
REQ-023 SHALL hold the identity dividend = quotient*divisor + remainder, computed modulo 2^WIDTH.

Reset
REQ-024 SHALL, while reset_n=0, force state to IDLE, ready=1, done=0, quotient=0, remainder=0 and div_by_zero=0, asynchronously.
REQ-025 SHALL abandon an operation in progress on reset, produce no done for it, and restart on the first accepted start after reset_n rises.

Configuration
REQ-026 SHALL recognise the macro SEQ_DIVIDER_SIGNED_EN.
REQ-027 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement.
REQ-028 SHALL then truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-029 SHALL then return, for the most-negative dividend divided by -1, quotient = the most-negative value and remainder=0.
REQ-030 SHALL, without SEQ_DIVIDER_SIGNED_EN, treat operands as unsigned; FIX still occupies its cycle.

Structure
REQ-031 SHALL take the state enum typedef and the default width constant from a shared package, div_pkg.
REQ-032 SHALL place one combinational iteration (shift, trial subtract, restore, quotient bit) in sub-module div_step, instantiated once.
REQ-033 SHALL hold all state in seq_divider; the pipelined multiplier stays untouched.

Verification
REQ-034 SHALL cover unsigned divide: 100/7 accepted at edge 0 -> done at edge 34, quotient=14, remainder=2, div_by_zero=0.
REQ-035 SHALL cover zero divisor: 0x12345678/0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, done at edge 34.
REQ-036 SHALL cover signed mode (-7)/2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
REQ-037 SHALL cover unsigned mode 0xFFFFFFF9/2 -> quotient=0x7FFFFFFC, remainder=1.
REQ-038 SHALL cover overflow in signed mode: 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-039 SHALL cover start held high during RUN with different operands -> ignored, and the first result is unchanged.
REQ-040 SHALL cover reset_n pulsed low at edge 10 of a run -> no done, outputs 0, ready=1; a new 9/3 then gives quotient=3, remainder=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: controller state encoding
// and the default operand width.
package div_pkg;

  // Controller states: idle, iterate, sign/zero fix-up, result pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Default operand and result width in bits.
  localparam int DIV_WIDTH_DEFAULT = 32;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// The partial remainder is shifted left taking in the next dividend bit
// (MSB of the quotient/dividend shift register), the divisor is trial
// subtracted, and the result is kept or restored. The new quotient bit is
// shifted into the LSB of the quotient/dividend register.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  // Partial remainder is always below the divisor, so the shifted value fits
  // in WIDTH+1 bits and a non-negative trial difference fits in WIDTH bits;
  // bit WIDTH of the difference is therefore a clean borrow flag.
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, i_dvs};
  assign w_fits    = ~w_trial[WIDTH];

  assign o_rem = w_fits ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

  // Quotient/dividend register shifts left by one, new quotient bit enters LSB.
  assign o_quo[0] = w_fits;
  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_quo_shift
      assign o_quo[gi] = i_quo[gi-1];
    end
  endgenerate

endmodule : div_step

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Flow: IDLE -> RUN (one operand conditioning cycle, then WIDTH iterations)
//       -> FIX (sign correction / zero-divisor override) -> DONE -> IDLE.
// done is high WIDTH+2 edges after the accepting edge.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's complement operands
// (quotient truncated toward zero, remainder takes the dividend's sign).
// Without it operands are unsigned; the FIX cycle is kept either way so the
// latency does not depend on the build.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Controller state and iteration counter. Count 0 is the conditioning
  // cycle; counts 1..WIDTH are the shift/subtract iterations.
  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;

  // Operands exactly as presented at the accepting edge.
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;

  // Working registers: partial remainder, quotient/dividend shifter, divisor
  // magnitude.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;

  // Registered outputs.
  logic             r_ready;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;
  logic             w_b_zero;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  assign w_b_zero = (r_op_b == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Divide magnitudes; the most-negative value's magnitude is 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  assign w_mag_a = r_op_a[WIDTH-1] ? -r_op_a : r_op_a;
  assign w_mag_b = r_op_b[WIDTH-1] ? -r_op_b : r_op_b;
`else
  assign w_mag_a = r_op_a;
  assign w_mag_b = r_op_b;
`endif

  // Final result: apply signs from the original operands, then let a zero
  // divisor override everything with all-ones quotient and dividend remainder.
  always_comb begin
    w_fix_quo = r_quo;
    w_fix_rem = r_rem;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (r_op_a[WIDTH-1] ^ r_op_b[WIDTH-1]) begin
      w_fix_quo = -r_quo;
    end
    if (r_op_a[WIDTH-1]) begin
      w_fix_rem = -r_rem;
    end
`endif
    if (w_b_zero) begin
      w_fix_quo = '1;
      w_fix_rem = r_op_a;
    end
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_ready     <= 1'b1;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op_a  <= dividend;
            r_op_b  <= divisor;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (r_cnt == '0) begin
            // Conditioning cycle: load magnitudes, clear partial remainder.
            r_rem <= '0;
            r_quo <= w_mag_a;
            r_dvs <= w_mag_b;
          end else begin
            r_rem <= w_step_rem;
            r_quo <= w_step_quo;
          end
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_FIX;
          end
          r_cnt <= r_cnt + CNT_ONE;
        end

        ST_FIX: begin
          r_quotient  <= w_fix_quo;
          r_remainder <= w_fix_rem;
          r_dbz       <= w_b_zero;
          r_done      <= 1'b1;
          r_state     <= ST_DONE;
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases plus random
// operands against an arithmetic reference model. Follows the
// SEQ_DIVIDER_SIGNED_EN build option for the model.
module tb_seq_divider;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain language-level division with the documented special cases.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    logic [W-1:0] min_neg;
    min_neg = {1'b1, {(W-1){1'b0}}};
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (a == min_neg && b == '1) begin
        q = min_neg;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // One complete operation: accept, measure latency, check results, check
  // single-cycle done and held outputs. Optionally keeps start asserted with
  // fresh operands during the run, which must be ignored.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start,
                        output logic [W-1:0] got_q, output logic [W-1:0] got_r);
    logic [W-1:0] eq, er;
    logic         ez;
    int           n;
    ref_div(a, b, eq, er, ez);
    @(negedge clock);
    chk("ready_idle", ready, 1);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    chk("ready_busy", ready, 0);
    if (hold_start) begin
      dividend = $urandom;
      divisor  = $urandom;
    end else begin
      start = 1'b0;
    end
    n = 0;
    while (!done && n < LAT + 6) begin
      @(posedge clock);
      #1;
      n++;
      if (n == LAT / 2) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    start = 1'b0;
    chk("latency", n, LAT);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    chk("ready_in_done", ready, 0);
    got_q = quotient;
    got_r = remainder;
    $display("op 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dbz=%0d latency=%0d",
             a, b, quotient, remainder, div_by_zero, n);
    @(posedge clock);
    #1;
    chk("done_pulse", done, 0);
    chk("ready_back", ready, 1);
    chk("q_held", quotient, eq);
    chk("r_held", remainder, er);
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic [W-1:0] ra, rb;
    int           seen;

    reset_n  = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed cases.
    run_op(32'd100, 32'd7, 1'b0, q, r);
    chk("100/7 q", q, 14);
    chk("100/7 r", r, 2);
    run_op(32'h1234_5678, 32'd0, 1'b0, q, r);
    chk("div0 q", q, 32'hFFFF_FFFF);
    chk("div0 r", r, 32'h1234_5678);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r);
`ifdef SEQ_DIVIDER_SIGNED_EN
    chk("-7/2 q", q, 32'hFFFF_FFFD);
    chk("-7/2 r", r, 32'hFFFF_FFFF);
`else
    chk("u 0xFFFFFFF9/2 q", q, 32'h7FFF_FFFC);
    chk("u 0xFFFFFFF9/2 r", r, 1);
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, q, r);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, q, r);
    run_op(32'd5, 32'd9, 1'b0, q, r);
    // Start held high with changing operands during the run.
    run_op(32'd1000, 32'd33, 1'b1, q, r);
    chk("held_start q", q, 30);
    chk("held_start r", r, 10);

    // Reset in the middle of a run.
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd12345;
    divisor  = 32'd11;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    repeat (LAT + 4) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    chk("midrst_no_done", seen, 0);
    chk("midrst_ready_idle", ready, 1);
    run_op(32'd9, 32'd3, 1'b0, q, r);
    chk("9/3 q", q, 3);
    chk("9/3 r", r, 0);

    // Random operands, with extra weight on small and zero divisors.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = -$urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) ra = $urandom_range(0, 100);
      run_op(ra, rb, ($urandom_range(0, 3) == 0), q, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_divider
